// File: rtl/alien_laser_pkg.sv
// Shared types, keycodes and key decode for the alien laser pool.
// Imported by the slot FSM and the pool top.
package alien_laser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEER = 2'd1,
    FALL  = 2'd2
  } slot_state_t;

  localparam logic [7:0] KEY_FIRE = 8'h2C;
  localparam logic [7:0] KEY_POS  = 8'h04;
  localparam logic [7:0] KEY_NEG  = 8'h07;

  function automatic logic key_pressed(
    input logic [47:0] keys,
    input logic [7:0]  code
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (keys[8*i +: 8] == code) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/alien_laser_slot.sv
// One projectile: spawn, steer window, fall, retire at bottom,
// hit clear and X saturation.
import alien_laser_pkg::*;

module alien_laser_slot #(
  parameter int STEER_FRAMES = 30,
  parameter int Y_STEP       = 6,
  parameter int X_STEP       = 2,
  parameter int GUN_Y        = 83,
  parameter int Y_MAX        = 462,
  parameter int LASER_H      = 8,
  parameter int X_LIM        = 635,
  parameter int PARK_X       = 0,
  parameter int PARK_Y       = 500
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       freeze,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic       hit,
  input  logic       pos,
  input  logic       neg,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       active_nxt
);

  localparam int SW = $clog2(STEER_FRAMES + 1);

  slot_state_t    state_q, state_d;
  logic [9:0]     x_q, x_d;
  logic [9:0]     y_q, y_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic           active_q;
  logic           live;
  logic           retire;
  logic signed [10:0] xs;
  logic [9:0]     x_sat;

  assign live   = (state_q != IDLE);
  assign retire = ({1'b0, y_q} + 11'(LASER_H)) >= 11'(Y_MAX);

  // Steering is done in signed 11 bits so a left step below 0 clamps
  always_comb begin
    xs = $signed({1'b0, x_q});
    if (pos && !neg) xs = xs + $signed(11'(X_STEP));
    if (neg && !pos) xs = xs - $signed(11'(X_STEP));
    if (xs < 0)
      x_sat = 10'd0;
    else if (xs > $signed(11'(X_LIM)))
      x_sat = 10'(X_LIM);
    else
      x_sat = xs[9:0];
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      if (hit && live) begin
        state_d = IDLE;
        x_d     = 10'(PARK_X);
        y_d     = 10'(PARK_Y);
      end else if (spawn && !live) begin
        state_d = STEER;
        x_d     = spawn_x;
        y_d     = 10'(GUN_Y);
        cnt_d   = '0;
      end else if (tick && live) begin
        if (retire) begin
          state_d = IDLE;
          x_d     = 10'(PARK_X);
          y_d     = 10'(PARK_Y);
        end else begin
          y_d = y_q + 10'(Y_STEP);
          if (state_q == STEER) begin
            x_d   = x_sat;
            cnt_d = cnt_q + SW'(1);
            if (cnt_q == SW'(STEER_FRAMES - 1))
              state_d = FALL;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      x_q      <= 10'(PARK_X);
      y_q      <= 10'(PARK_Y);
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      active_q <= (state_d != IDLE);
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign active     = active_q;
  assign active_nxt = (state_d != IDLE);

endmodule

// File: rtl/alien_laser_pool.sv
// Pool of alien projectiles: frame tick, key decode, cooldown, slot
// allocation, gameover latch. ALIEN_LASER_AUTO_FIRE_EN: held key re-fires.
import alien_laser_pkg::*;

module alien_laser_pool #(
  parameter int         NUM_LASERS      = 4,
  parameter int         STEER_FRAMES    = 30,
  parameter int         COOLDOWN_FRAMES = 20,
  parameter int         Y_STEP          = 6,
  parameter int         X_STEP          = 2,
  parameter int         GUN_X_OFF       = 14,
  parameter int         GUN_Y           = 83,
  parameter int         Y_MAX           = 462,
  parameter int         LASER_H         = 8,
  parameter int         LASER_W         = 4,
  parameter int         X_MAX           = 639,
  parameter int         PARK_X          = 0,
  parameter int         PARK_Y          = 500,
  parameter logic [7:0] FIRE_KEY        = KEY_FIRE,
  parameter logic [7:0] POS_KEY         = KEY_POS,
  parameter logic [7:0] NEG_KEY         = KEY_NEG
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic                    GG,
  input  logic [47:0]             keys,
  input  logic [9:0]              AlienX,
  input  logic [NUM_LASERS-1:0]   hit,
  output logic [10*NUM_LASERS-1:0] laser_x,
  output logic [10*NUM_LASERS-1:0] laser_y,
  output logic [NUM_LASERS-1:0]   laser_active,
  output logic                    busy_full
);

  localparam int X_LIM = X_MAX - LASER_W;
  localparam int CW    = $clog2(COOLDOWN_FRAMES + 1);

  logic            fc1_q, fc2_q;
  logic            fire_prev_q, fire_prev_d;
  logic [CW-1:0]   cool_q, cool_d, cool_dec;
  logic            gameover_q, gameover_d;
  logic            busy_q, busy_d;
  logic            tick;
  logic            fire_now, pos_now, neg_now, edge_ok;
  logic            accept, taken;
  logic [10:0]     gun_sum;
  logic [9:0]      spawn_x;
  logic [NUM_LASERS-1:0] free, spawn, act_nxt;

  assign tick     = fc1_q & ~fc2_q;
  assign fire_now = key_pressed(keys, FIRE_KEY);
  assign pos_now  = key_pressed(keys, POS_KEY);
  assign neg_now  = key_pressed(keys, NEG_KEY);
  assign free     = ~laser_active;

`ifdef ALIEN_LASER_AUTO_FIRE_EN
  assign edge_ok = 1'b1;
`else
  assign edge_ok = ~fire_prev_q;
`endif

  assign gun_sum = {1'b0, AlienX} + 11'(GUN_X_OFF);
  assign spawn_x = (gun_sum > 11'(X_LIM)) ? 10'(X_LIM) : gun_sum[9:0];

  // Gate on the value cooldown reaches this tick, so re-fire spacing
  // is exactly COOLDOWN_FRAMES ticks
  always_comb begin
    cool_dec = (cool_q != '0) ? cool_q - CW'(1) : '0;
    accept   = tick && fire_now && edge_ok && (cool_dec == '0) &&
               !gameover_q && (|free);
    spawn = '0;
    taken = 1'b0;
    for (int i = 0; i < NUM_LASERS; i++) begin
      if (accept && free[i] && !taken) begin
        spawn[i] = 1'b1;
        taken    = 1'b1;
      end
    end
    cool_d = cool_q;
    if (tick) cool_d = accept ? CW'(COOLDOWN_FRAMES) : cool_dec;
    fire_prev_d = tick ? fire_now : fire_prev_q;
    gameover_d  = gameover_q | GG;
    busy_d      = &act_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc1_q       <= 1'b0;
      fc2_q       <= 1'b0;
      fire_prev_q <= 1'b0;
      cool_q      <= '0;
      gameover_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fc1_q       <= frame_clk;
      fc2_q       <= fc1_q;
      fire_prev_q <= fire_prev_d;
      cool_q      <= cool_d;
      gameover_q  <= gameover_d;
      busy_q      <= busy_d;
    end
  end

  assign busy_full = busy_q;

  for (genvar i = 0; i < NUM_LASERS; i++) begin : g_slot
    alien_laser_slot #(
      .STEER_FRAMES (STEER_FRAMES),
      .Y_STEP       (Y_STEP),
      .X_STEP       (X_STEP),
      .GUN_Y        (GUN_Y),
      .Y_MAX        (Y_MAX),
      .LASER_H      (LASER_H),
      .X_LIM        (X_LIM),
      .PARK_X       (PARK_X),
      .PARK_Y       (PARK_Y)
    ) u_slot (
      .Clk        (Clk),
      .Reset      (Reset),
      .tick       (tick),
      .freeze     (gameover_q),
      .spawn      (spawn[i]),
      .spawn_x    (spawn_x),
      .hit        (hit[i]),
      .pos        (pos_now),
      .neg        (neg_now),
      .x          (laser_x[10*i +: 10]),
      .y          (laser_y[10*i +: 10]),
      .active     (laser_active[i]),
      .active_nxt (act_nxt[i])
    );
  end

endmodule

// File: tb/tb_alien_laser_pool.sv
// Directed bench for alien_laser_pool with hand-computed expectations.
// Covers spawn, steer, retire, cooldown, allocation, hit, gameover.
module tb_alien_laser_pool;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic        GG;
  logic [47:0] keys;
  logic [9:0]  AlienX;
  logic [3:0]  hit;
  logic [39:0] laser_x;
  logic [39:0] laser_y;
  logic [3:0]  laser_active;
  logic        busy_full;

  int vectors = 0;
  int errors  = 0;

  alien_laser_pool dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .GG           (GG),
    .keys         (keys),
    .AlienX       (AlienX),
    .hit          (hit),
    .laser_x      (laser_x),
    .laser_y      (laser_y),
    .laser_active (laser_active),
    .busy_full    (busy_full)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [47:0] mk(input logic f, input logic p,
                                     input logic n);
    logic [47:0] k;
    k = '0;
    if (f) k[23:16] = 8'h2C;
    if (p) k[7:0]   = 8'h04;
    if (n) k[47:40] = 8'h07;
    return k;
  endfunction

  function automatic logic [9:0] xo(input int i);
    return laser_x[10*i +: 10];
  endfunction

  function automatic logic [9:0] yo(input int i);
    return laser_y[10*i +: 10];
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic tick();
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  // hit asserted exactly in the Clk cycle where the tick is high
  task automatic tick_hit(input logic [3:0] h);
    frame_clk = 1'b1;
    @(posedge Clk);
    #1 hit = h;
    @(posedge Clk);
    #1 hit = '0;
    @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic pulse_hit(input logic [3:0] h);
    hit = h;
    @(posedge Clk);
    #1 hit = '0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic check_parked(input string tag);
    check({tag, "_x"}, laser_x, 40'd0);
    check({tag, "_y"}, laser_y, {4{10'd500}});
    check({tag, "_act"}, laser_active, 4'b0000);
    check({tag, "_busy"}, busy_full, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; GG = 1'b0;
    keys = '0; AlienX = 10'd100; hit = '0;
    @(posedge Clk);
    #1;
    do_reset();
    check_parked("reset");

    // spawn, straight fall, retire at bottom
    keys = mk(1, 0, 0); tick(); keys = '0;
    check("spawn_x", xo(0), 10'd114);
    check("spawn_y", yo(0), 10'd83);
    check("spawn_act", laser_active, 4'b0001);
    repeat (62) tick();
    check("fall_y62", yo(0), 10'd455);
    check("fall_act62", laser_active, 4'b0001);
    tick();
    check_parked("retire");

    // steering window: 30 steps of +2, then frozen X
    do_reset();
    keys = mk(1, 1, 0); tick();
    check("steer_spawn_x", xo(0), 10'd114);
    keys = mk(0, 1, 0);
    repeat (30) tick();
    check("steer30_x", xo(0), 10'd174);
    repeat (10) tick();
    check("steer40_x", xo(0), 10'd174);
    check("steer40_y", yo(0), 10'd323);

    // both keys cancel, then NEG only
    do_reset();
    keys = mk(1, 0, 0); tick();
    keys = mk(0, 1, 1);
    repeat (5) tick();
    check("both_x", xo(0), 10'd114);
    keys = mk(0, 0, 1);
    repeat (3) tick();
    check("neg_x", xo(0), 10'd108);

    // right saturation at spawn and while steering
    do_reset();
    AlienX = 10'd630;
    keys = mk(1, 0, 1); tick();
    check("sat_spawn_x", xo(0), 10'd635);
    keys = mk(0, 1, 0);
    repeat (4) tick();
    check("sat_pos_x", xo(0), 10'd635);
    keys = mk(0, 0, 1); tick();
    check("sat_neg_x", xo(0), 10'd633);

    // left saturation: 14 -> 0 in 7 steps, 8th step clamps
    do_reset();
    AlienX = 10'd0;
    keys = mk(1, 0, 1); tick();
    check("lsat_spawn_x", xo(0), 10'd14);
    repeat (8) tick();
    check("lsat_x", xo(0), 10'd0);
    check("lsat_act", laser_active, 4'b0001);

    // cooldown spacing, fill, retire, same-cycle hit exclusion
    do_reset();
    AlienX = 10'd100;
    for (int t = 0; t <= 100; t++) begin
      keys = (t % 2 == 0) ? mk(1, 0, 0) : '0;
      if (t == 100) tick_hit(4'b0001);
      else tick();
      case (t)
        19: check("cd_t19_act", laser_active, 4'b0001);
        20: check("cd_t20_act", laser_active, 4'b0011);
        40: check("cd_t40_act", laser_active, 4'b0111);
        60: begin
          check("full_act", laser_active, 4'b1111);
          check("full_busy", busy_full, 1'b1);
        end
        63: begin
          check("t63_act", laser_active, 4'b1110);
          check("t63_busy", busy_full, 1'b0);
        end
        80: check("t80_act", laser_active, 4'b1111);
        83: check("t83_act", laser_active, 4'b1101);
        100: begin
          check("hitfire_act", laser_active, 4'b1110);
          check("hitfire_x1", xo(1), 10'd114);
          check("hitfire_y1", yo(1), 10'd83);
          check("hitfire_y0", yo(0), 10'd500);
        end
        default: ;
      endcase
    end

    // held fire key: one shot without auto-fire, every 20 ticks with it
    do_reset();
    keys = mk(1, 0, 0);
    repeat (41) tick();
`ifdef ALIEN_LASER_AUTO_FIRE_EN
    check("hold_act", laser_active, 4'b0111);
`else
    check("hold_act", laser_active, 4'b0001);
`endif
    keys = '0;

    // gameover freeze, then reset clears everything
    do_reset();
    for (int t = 0; t <= 20; t++) begin
      keys = (t % 2 == 0) ? mk(1, 0, 0) : '0;
      tick();
    end
    check("gg_pre_act", laser_active, 4'b0011);
    GG = 1'b1;
    @(posedge Clk);
    #1 GG = 1'b0;
    for (int t = 0; t < 10; t++) begin
      keys = (t % 2 == 0) ? mk(1, 1, 0) : mk(0, 1, 0);
      tick();
      if (t == 4) pulse_hit(4'b0011);
    end
    keys = '0;
    check("gg_y", laser_y, {10'd500, 10'd500, 10'd83, 10'd203});
    check("gg_x", laser_x, {10'd0, 10'd0, 10'd114, 10'd114});
    check("gg_act", laser_active, 4'b0011);
    do_reset();
    check_parked("gg_reset");
    keys = mk(1, 0, 0); tick(); keys = '0;
    check("gg_clear_act", laser_active, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
